// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised inter-stage pipeline register with valid/ready
//               handshake, optional skid entry, flush and stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
    parameter int DATA_W = 101,
    parameter int CTRL_W = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // Main entry: always the word presented downstream
    logic              r_valid_m;
    logic [DATA_W-1:0] r_data_m;
    logic [CTRL_W-1:0] r_ctrl_m;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_in_ready;
    logic w_acc;
    logic w_dep;
    logic w_stalled;

    assign w_acc     = in_valid & w_in_ready;
    assign w_dep     = r_valid_m & out_ready;
    assign w_stalled = r_valid_m & ~out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              r_valid_s;
            logic [DATA_W-1:0] r_data_s;
            logic [CTRL_W-1:0] r_ctrl_s;

            // Ready depends only on state, so no combinational path from out_ready
            assign w_in_ready = ~r_valid_s;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid_m <= 1'b0;
                    r_data_m  <= '0;
                    r_ctrl_m  <= '0;
                    r_valid_s <= 1'b0;
                    r_data_s  <= '0;
                    r_ctrl_s  <= '0;
                end else if (flush) begin
                    r_valid_m <= 1'b0;
                    r_ctrl_m  <= '0;
                    r_valid_s <= 1'b0;
                    r_ctrl_s  <= '0;
                end else if (!r_valid_m || out_ready) begin
                    if (r_valid_s) begin
                        // Skid word is older than anything arriving now
                        r_valid_m <= 1'b1;
                        r_data_m  <= r_data_s;
                        r_ctrl_m  <= r_ctrl_s;
                        r_valid_s <= w_acc;
                        if (w_acc) begin
                            r_data_s <= in_data;
                            r_ctrl_s <= in_ctrl;
                        end
                    end else if (w_acc) begin
                        r_valid_m <= 1'b1;
                        r_data_m  <= in_data;
                        r_ctrl_m  <= in_ctrl;
                    end else begin
                        r_valid_m <= 1'b0;
                    end
                end else if (w_acc) begin
                    r_valid_s <= 1'b1;
                    r_data_s  <= in_data;
                    r_ctrl_s  <= in_ctrl;
                end
            end
        end else begin : g_noskid
            assign w_in_ready = ~r_valid_m | out_ready;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid_m <= 1'b0;
                    r_data_m  <= '0;
                    r_ctrl_m  <= '0;
                end else if (flush) begin
                    r_valid_m <= 1'b0;
                    r_ctrl_m  <= '0;
                end else if (w_acc) begin
                    r_valid_m <= 1'b1;
                    r_data_m  <= in_data;
                    r_ctrl_m  <= in_ctrl;
                end else if (w_dep) begin
                    r_valid_m <= 1'b0;
                end
            end
        end
    endgenerate

    // Counts stalled cycles regardless of flush; only reset clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stalled && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid_m;
    assign out_data  = r_data_m;
    assign out_ctrl  = r_valid_m ? r_ctrl_m : '0;
    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg (SKID=1, SKID=0, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam int DW = 101;
    localparam int CW = 5;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          flush;
    logic          out_ready;

    logic [2:0]          ir;
    logic [2:0]          ov;
    logic [2:0][DW-1:0]  od;
    logic [2:0][CW-1:0]  oc;
    logic [15:0]         sc0;
    logic [15:0]         sc1;
    logic [3:0]          sc2;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_dut_skid (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .out_ctrl(oc[0]), .stall_cnt(sc0)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_dut_noskid (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .out_ctrl(oc[1]), .stall_cnt(sc1)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_dut_cnt4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(od[2]), .out_ctrl(oc[2]), .stall_cnt(sc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each instance is a FIFO of capacity 1 or 2
    logic [DW-1:0] md [3][2];
    logic [CW-1:0] mc [3][2];
    int            mn [3];
    int            msc[3];
    int            depth[3] = '{2, 1, 2};
    int            smax [3] = '{65535, 65535, 15};

    function automatic logic m_ir(input int d);
        if (depth[d] == 2) return (mn[d] < 2);
        return (mn[d] == 0) || out_ready;
    endfunction

    function automatic logic [15:0] dut_sc(input int d);
        if (d == 0) return sc0;
        if (d == 1) return sc1;
        return {12'd0, sc2};
    endfunction

    task automatic check_model();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d_in_ready", d), {127'd0, ir[d]}, {127'd0, m_ir(d)});
            chk($sformatf("d%0d_out_valid", d), {127'd0, ov[d]}, {127'd0, (mn[d] > 0)});
            chk($sformatf("d%0d_out_ctrl", d), {123'd0, oc[d]},
                (mn[d] > 0) ? {123'd0, mc[d][0]} : 128'd0);
            if (mn[d] > 0)
                chk($sformatf("d%0d_out_data", d), {27'd0, od[d]}, {27'd0, md[d][0]});
            chk($sformatf("d%0d_stall_cnt", d), {112'd0, dut_sc(d)}, 128'(msc[d]));
        end
        chk("noskid_ready_rel", {127'd0, ir[1]}, {127'd0, (~ov[1] | out_ready)});
    endtask

    task automatic advance();
        logic acc [3];
        logic dep [3];
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            acc[d] = in_valid & m_ir(d);
            dep[d] = (mn[d] > 0) & out_ready;
        end
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                mn[d]  = 0;
                msc[d] = 0;
            end else begin
                if (mn[d] > 0 && !out_ready && msc[d] < smax[d]) msc[d]++;
                if (flush) begin
                    mn[d] = 0;
                end else begin
                    if (dep[d]) begin
                        md[d][0] = md[d][1];
                        mc[d][0] = mc[d][1];
                        mn[d]--;
                    end
                    if (acc[d]) begin
                        md[d][mn[d]] = in_data;
                        mc[d][mn[d]] = in_ctrl;
                        mn[d]++;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
        advance();
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = {93'd0, d};
        in_ctrl   = d[4:0] | 5'h10;
        out_ready = ordy;
    endtask

    typedef struct {
        logic        iv;
        logic [7:0]  d;
        logic        ordy;
        logic        ev;
        logic [7:0]  ed;
        logic        eir;
        logic [15:0] esc;
    } vec_t;

    vec_t vecs[32];
    int   nvec;

    task automatic add(input logic iv, input logic [7:0] d, input logic ordy,
                       input logic ev, input logic [7:0] ed, input logic eir,
                       input logic [15:0] esc);
        vecs[nvec] = '{iv, d, ordy, ev, ed, eir, esc};
        nvec++;
    endtask

    initial begin
        logic [127:0] rnd;
        n_chk = 0;
        n_err = 0;
        nvec  = 0;
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 8'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            mn[d]  = 0;
            msc[d] = 0;
        end
        reset = 1'b0;

        // Stream 1..6 with downstream stalled for three cycles
        add(1, 1, 1,  0, 0, 1, 0);
        add(1, 2, 1,  1, 1, 1, 0);
        add(1, 3, 0,  1, 2, 1, 0);
        add(1, 4, 0,  1, 2, 0, 1);
        add(1, 4, 0,  1, 2, 0, 2);
        add(1, 4, 1,  1, 2, 0, 3);
        add(1, 4, 1,  1, 3, 1, 3);
        add(1, 5, 1,  1, 4, 1, 3);
        add(1, 6, 1,  1, 5, 1, 3);
        add(0, 0, 1,  1, 6, 1, 3);
        add(0, 0, 1,  0, 0, 1, 3);
        // Back-to-back 1..8 with no backpressure
        for (int j = 1; j <= 8; j++)
            add(1, 8'(j), 1, (j > 1), 8'(j - 1), 1, 3);
        add(0, 0, 1,  1, 8, 1, 3);
        add(0, 0, 1,  0, 0, 1, 3);

        @(negedge clk);
        chk("reset_out_valid", {127'd0, ov[0]}, 128'd0);
        chk("reset_in_ready", {127'd0, ir[0]}, 128'd1);
        chk("reset_stall_cnt", {112'd0, sc0}, 128'd0);
        check_model();
        advance();

        for (int i = 0; i < nvec; i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].ordy);
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", i), {127'd0, ov[0]}, {127'd0, vecs[i].ev});
            chk($sformatf("vec%0d_in_ready", i), {127'd0, ir[0]}, {127'd0, vecs[i].eir});
            chk($sformatf("vec%0d_stall_cnt", i), {112'd0, sc0}, {112'd0, vecs[i].esc});
            chk($sformatf("vec%0d_out_ctrl", i), {123'd0, oc[0]},
                vecs[i].ev ? {123'd0, (vecs[i].ed[4:0] | 5'h10)} : 128'd0);
            if (vecs[i].ev)
                chk($sformatf("vec%0d_out_data", i), {27'd0, od[0]}, {120'd0, vecs[i].ed});
            check_model();
            advance();
        end

        // Flush with M=0xA, S=0xB and 0xC offered in the flush cycle
        drive(1'b1, 8'h0A, 1'b0); step();
        drive(1'b1, 8'h0B, 1'b0); step();
        drive(1'b1, 8'h0C, 1'b0); flush = 1'b1; step();
        flush = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_out_valid", {127'd0, ov[0]}, 128'd0);
            chk("flush_out_ctrl", {123'd0, oc[0]}, 128'd0);
            check_model();
            advance();
        end

        // Reset for two cycles with both entries full
        drive(1'b1, 8'h11, 1'b0); step();
        drive(1'b1, 8'h22, 1'b0); step();
        reset = 1'b1;
        drive(1'b1, 8'h33, 1'b0); step(); step();
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("midrst_out_valid", {127'd0, ov[0]}, 128'd0);
        chk("midrst_out_ctrl", {123'd0, oc[0]}, 128'd0);
        chk("midrst_out_data", {27'd0, od[0]}, 128'd0);
        chk("midrst_stall_cnt", {112'd0, sc0}, 128'd0);
        chk("midrst_in_ready", {127'd0, ir[0]}, 128'd1);
        check_model();
        advance();

        // Narrow counter saturates and survives flush
        drive(1'b1, 8'h33, 1'b0); step();
        drive(1'b0, 8'h00, 1'b0);
        repeat (20) step();
        @(negedge clk);
        chk("cnt4_saturated", {124'd0, sc2}, 128'd15);
        check_model();
        advance();
        flush = 1'b1; step();
        flush = 1'b0;
        @(negedge clk);
        chk("cnt4_after_flush", {124'd0, sc2}, 128'd15);
        chk("cnt4_flush_valid", {127'd0, ov[2]}, 128'd0);
        check_model();
        advance();

        // Randomised traffic against the model
        for (int k = 0; k < 600; k++) begin
            rnd       = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = rnd[DW-1:0];
            in_ctrl   = CW'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        flush = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
